// File: rtl/sevenseg_snoop_if.sv
// Multiplexed active-low 7-segment display bus: digit anodes plus shared segment lines.
// The display driver owns the bus; snoopers only observe it.
interface sevenseg_snoop_if #(
  parameter int NDIG = 4
);
  logic [NDIG-1:0] an;
  logic [6:0]      seg;

  modport master (output an, output seg);
  modport slave  (input  an, input  seg);
endinterface

// File: rtl/sevenseg_snoop.sv
// Passive readback of a multiplexed 7-segment display: waits for each digit's drive to settle,
// then decodes the segment pattern into a per-digit nibble with blank/illegal/ambiguous flags.
module sevenseg_snoop #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  sevenseg_snoop_if.slave     bus,
  input  logic                err_clr,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     dig_valid,
  output logic [NDIG-1:0]     blank,
  output logic [NDIG-1:0]     ambig,
  output logic                upd,
  output logic [2:0]          upd_idx,
  output logic                err
);

  localparam int SW = NDIG + 7;
  localparam int CW = (STABLE > 2) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 2);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s_q, p_q;
  logic [CW-1:0]   cnt;
  logic            chg;
  logic [NDIG-1:0] en;
  logic            one_hot;
  logic [2:0]      idx;
  logic [6:0]      seg_q;
  logic            capture;

  logic [3:0]      dec_nib;
  logic            dec_legal;
  logic            dec_blank;
  logic            dec_ambig;

  // The bus is sampled once; p_q holds the previous sample so changes are seen one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= {bus.an, bus.seg};
      p_q <= s_q;
    end
  end

  assign chg     = (s_q != p_q);
  assign en      = ~s_q[SW-1:7];
  assign seg_q   = s_q[6:0];
  assign one_hot = $onehot(en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (chg) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (en[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // CAPTURE is entered one count early so the write lands STABLE+1 edges after the bus settled;
  // a change seen during CAPTURE still aborts the write.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (one_hot) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (chg)                   state_nxt = one_hot ? SETTLE : IDLE;
        else if (cnt == CNT_LAST)  state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (chg) begin
          state_nxt = one_hot ? SETTLE : IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (chg) state_nxt = one_hot ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // 0x03 is the lit pattern shared by '6' and 'b'; it decodes as 6 but is flagged ambiguous.
  always_comb begin
    dec_nib   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_ambig = 1'b0;
    case (seg_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h03: begin
        dec_nib   = 4'h6;
        dec_ambig = 1'b1;
      end
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits    <= '0;
      dig_valid <= '0;
      blank     <= '0;
      ambig     <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
    end else begin
      upd <= capture;
      if (capture) upd_idx <= idx;
      for (int i = 0; i < NDIG; i++) begin
        if (capture && idx == 3'(i)) begin
          if (dec_blank) begin
            dig_valid[i] <= 1'b1;
            blank[i]     <= 1'b1;
            ambig[i]     <= 1'b0;
          end else if (dec_legal) begin
            digits[4*i +: 4] <= dec_nib;
            dig_valid[i]     <= 1'b1;
            blank[i]         <= 1'b0;
            ambig[i]         <= dec_ambig;
          end else begin
            dig_valid[i] <= 1'b0;
            blank[i]     <= 1'b0;
            ambig[i]     <= 1'b0;
          end
        end
      end
    end
  end

  // An illegal capture in the same cycle as err_clr leaves err set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (capture && !dec_legal && !dec_blank) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  upd_not_back_to_back: assert property (@(posedge clk) disable iff (!reset_n) upd |=> !upd);

endmodule

// File: tb/tb_sevenseg_snoop.sv
// Randomized scoreboard bench for sevenseg_snoop: a run-length display model predicts each
// capture, and a monitor compares every upd strobe against the queued prediction.
module tb_sevenseg_snoop;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                err_clr;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     dig_valid, blank, ambig;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                err;

  sevenseg_snoop_if #(.NDIG(NDIG)) bus ();

  sevenseg_snoop #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .err_clr   (err_clr),
    .digits    (digits),
    .dig_valid (dig_valid),
    .blank     (blank),
    .ambig     (ambig),
    .upd       (upd),
    .upd_idx   (upd_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        idx;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   ambig;
    logic              err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int upd_count = 0;

  logic [6:0] tbl_seg [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h03, 7'h78,
                               7'h00, 7'h18, 7'h10, 7'h08, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] tbl_nib [17] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NDIG-1:0] a, input logic [6:0] s, input int cycles,
                               input logic clr);
    bus.an  = a;
    bus.seg = s;
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Reference model: a value captures once it has been sampled STABLE+1 times in a row with
  // exactly one anode low; the digit registers change one edge later.
  logic [4*NDIG-1:0] m_digits;
  logic [NDIG-1:0]   m_valid, m_blank, m_ambig;
  logic              m_err;
  logic [NDIG+6:0]   m_prev, m_pend_val, m_cur;
  int                m_run;
  bit                m_pend;

  initial begin
    bit         found, illegal;
    logic [3:0] nib;
    logic [6:0] sg;
    int         di;
    exp_t       e;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_digits = '0; m_valid = '0; m_blank = '0; m_ambig = '0; m_err = 1'b0;
        m_prev = '0; m_run = 0; m_pend = 1'b0;
      end else begin
        illegal = 1'b0;
        if (m_pend) begin
          sg = m_pend_val[6:0];
          di = 0;
          for (int i = 0; i < NDIG; i++) if (!m_pend_val[7+i]) di = i;
          found = 1'b0;
          nib = 4'h0;
          for (int k = 0; k < 17; k++) begin
            if (tbl_seg[k] == sg) begin
              found = 1'b1;
              nib = tbl_nib[k];
            end
          end
          if (sg == 7'h7F) begin
            m_valid[di] = 1'b1; m_blank[di] = 1'b1; m_ambig[di] = 1'b0;
          end else if (found) begin
            m_digits[4*di +: 4] = nib;
            m_valid[di] = 1'b1; m_blank[di] = 1'b0; m_ambig[di] = (sg == 7'h03);
          end else begin
            m_valid[di] = 1'b0; m_blank[di] = 1'b0; m_ambig[di] = 1'b0;
            illegal = 1'b1;
          end
        end
        if (illegal)      m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (m_pend) begin
          e.idx = 3'(di); e.digits = m_digits; e.valid = m_valid;
          e.blank = m_blank; e.ambig = m_ambig; e.err = m_err;
          exp_q.push_back(e);
        end
        m_cur = {bus.an, bus.seg};
        if (m_cur != m_prev)  m_run = 1;
        else if (m_run < 1000) m_run++;
        m_prev = m_cur;
        m_pend = (m_run == STABLE + 1) && ($countones(~bus.an) == 1);
        m_pend_val = m_cur;
      end
    end
  end

  // Monitor: every upd strobe must match the oldest prediction.
  initial begin
    bit   prev_upd;
    exp_t e;
    prev_upd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (upd === 1'b1) begin
          upd_count++;
          checkOutput("upd_back_to_back", 32'(prev_upd), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_upd: got upd=1 idx=%0d, expected no capture at %0t",
                     upd_idx, $time);
          end else begin
            e = exp_q.pop_front();
            checkOutput("upd_idx",   32'(upd_idx),   32'(e.idx));
            checkOutput("digits",    32'(digits),    32'(e.digits));
            checkOutput("dig_valid", 32'(dig_valid), 32'(e.valid));
            checkOutput("blank",     32'(blank),     32'(e.blank));
            checkOutput("ambig",     32'(ambig),     32'(e.ambig));
            checkOutput("err_upd",   32'(err),       32'(e.err));
          end
        end
        checkOutput("err_track", 32'(err), 32'(m_err));
      end
      prev_upd = upd;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_digits"}, 32'(digits), 32'd0);
    checkOutput({tag, "_valid"},  32'(dig_valid), 32'd0);
    checkOutput({tag, "_blank"},  32'(blank), 32'd0);
    checkOutput({tag, "_ambig"},  32'(ambig), 32'd0);
    checkOutput({tag, "_upd"},    32'(upd), 32'd0);
    checkOutput({tag, "_updidx"}, 32'(upd_idx), 32'd0);
    checkOutput({tag, "_err"},    32'(err), 32'd0);
  endtask

  logic [6:0] scan_seg [4] = '{7'h79, 7'h30, 7'h08, 7'h0E};

  initial begin
    int         base, lat;
    logic [NDIG-1:0] a;
    logic [6:0] s;
    reset_n = 1'b0;
    err_clr = 1'b0;
    bus.an  = '1;
    bus.seg = 7'h7F;
    @(negedge clk);

    $display("[TB] reset with toggling inputs");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(NDIG'($urandom), 7'($urandom), 1, 1'b0);
      checkAllZero("reset");
    end
    bus.an = '1; bus.seg = 7'h7F;
    @(negedge clk);
    reset_n = 1'b1;
    base = upd_count;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_no_upd", 32'(upd_count - base), 32'd0);

    $display("[TB] basic capture and latency");
    bus.an = 4'b1110; bus.seg = 7'h24;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (upd === 1'b1) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(STABLE + 2));
    repeat (4) @(negedge clk);
    checkOutput("digit0_is_2", 32'(digits[3:0]), 32'h2);
    checkOutput("valid0", 32'(dig_valid[0]), 32'd1);

    $display("[TB] full scan");
    base = upd_count;
    for (int i = 0; i < 4; i++) applyStimulus(~(NDIG'(1) << i), scan_seg[i], 10, 1'b0);
    checkOutput("scan_digits", 32'(digits), 32'hFA31);
    checkOutput("scan_upd_count", 32'(upd_count - base), 32'd4);

    $display("[TB] glitch reject");
    base = upd_count;
    for (int k = 0; k < 10; k++) applyStimulus(4'b1101, (k % 2) ? 7'h40 : 7'h79, 2, 1'b0);
    checkOutput("glitch_no_upd", 32'(upd_count - base), 32'd0);
    applyStimulus(4'b1101, 7'h46, 10, 1'b0);
    checkOutput("digit1_is_C", 32'(digits[7:4]), 32'hC);

    $display("[TB] illegal and ambiguous");
    applyStimulus(4'b1011, 7'h55, 10, 1'b0);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_valid2", 32'(dig_valid[2]), 32'd0);
    checkOutput("bad_digit2_kept", 32'(digits[11:8]), 32'hA);
    applyStimulus(4'b1011, 7'h03, 10, 1'b0);
    checkOutput("ambig_digit2", 32'(digits[11:8]), 32'h6);
    checkOutput("ambig2", 32'(ambig[2]), 32'd1);
    checkOutput("err_still_set", 32'(err), 32'd1);
    applyStimulus(4'b1011, 7'h03, 2, 1'b1);
    checkOutput("err_cleared", 32'(err), 32'd0);

    $display("[TB] anode faults and mid-settle reset");
    base = upd_count;
    applyStimulus(4'b1111, 7'h40, 10, 1'b0);
    applyStimulus(4'b1100, 7'h40, 10, 1'b0);
    checkOutput("anode_fault_no_upd", 32'(upd_count - base), 32'd0);
    applyStimulus(4'b1110, 7'h40, 2, 1'b0);
    reset_n = 1'b0;
    bus.an = '1; bus.seg = 7'h7F;
    @(negedge clk);
    checkAllZero("midreset");
    reset_n = 1'b1;
    base = upd_count;
    applyStimulus(4'b1111, 7'h7F, 10, 1'b0);
    checkOutput("midreset_no_capture", 32'(upd_count - base), 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) a = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
      else                          a = NDIG'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    s = 7'($urandom);
        2:       s = 7'h7F;
        default: s = tbl_seg[$urandom_range(0, 16)];
      endcase
      applyStimulus(a, s, $urandom_range(1, 8), ($urandom_range(0, 15) == 0));
    end
    applyStimulus('1, 7'h7F, 10, 1'b0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
